// File: rtl/metric_pkg.sv
// Shared types and defaults for the path-metric minimum tracker and its comparator.
package metric_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int DEF_WIDTH   = 6;
    localparam int DEF_NSTATES = 64;

    function automatic int idx_width(input int nstates);
        return (nstates > 1) ? $clog2(nstates) : 1;
    endfunction

endpackage

// File: rtl/metric_lt.sv
// Combinational a < b built from a subtract, signed (sign xor overflow) or unsigned (no carry out).
module metric_lt #(
    parameter int WIDTH  = 6,
    parameter int SIGNED = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt
);

    logic             carry;
    logic             sign;
    logic [WIDTH-2:0] low_unused;
    logic             ovf;

    // Only the sign and carry of a + ~b + 1 decide the result; the low difference bits are not needed here.
    assign {carry, sign, low_unused} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ sign);
    assign lt  = (SIGNED != 0) ? (sign ^ ovf) : ~carry;

endmodule

// File: rtl/metric_min_tracker.sv
// Streaming minimum finder: tracks the smallest metric and its beat index per frame, then holds the result.
//
// state | meaning
// ACCUM | accepting beats, updating running minimum and index
// HOLD  | frame result presented on out_*, waiting for out_ready
module metric_min_tracker
    import metric_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NSTATES = DEF_NSTATES,
    parameter int SIGNED  = 1,
    parameter int IW      = idx_width(NSTATES),
    parameter int CW      = $clog2(NSTATES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_metric,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IW-1:0]    out_index,
    output logic [CW-1:0]    out_count,
    output logic             out_err
);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] min_r;
    logic [IW-1:0]    idx_r;

    logic             first_beat;
    logic             last_pos;
    logic             lt;
    logic             take;
    logic [WIDTH-1:0] new_min;
    logic [IW-1:0]    new_idx;

    metric_lt #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_lt (
        .a  (in_metric),
        .b  (min_r),
        .lt (lt)
    );

    assign in_ready   = (state == ACCUM);
    assign out_valid  = (state == HOLD);

    assign first_beat = (cnt == '0);
    assign last_pos   = (cnt == CW'(NSTATES - 1));
    // Strict compare keeps the earlier index on ties.
    assign take       = first_beat || lt;
    assign new_min    = take ? in_metric : min_r;
    assign new_idx    = take ? cnt[IW-1:0] : idx_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACCUM;
            cnt       <= '0;
            min_r     <= '0;
            idx_r     <= '0;
            out_min   <= '0;
            out_index <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        min_r <= new_min;
                        idx_r <= new_idx;
                        if (in_last || last_pos) begin
                            out_min   <= new_min;
                            out_index <= new_idx;
                            out_count <= cnt + 1'b1;
                            out_err   <= last_pos && !in_last;
                            state     <= HOLD;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_metric_min_tracker.sv
// Directed bench for metric_min_tracker: signed and unsigned instances with NSTATES=4 share one input stream.
module tb_metric_min_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [5:0] in_metric = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_s, out_valid_s, out_err_s;
    logic [5:0] out_min_s;
    logic [1:0] out_index_s;
    logic [2:0] out_count_s;

    logic       in_ready_u, out_valid_u, out_err_u;
    logic [5:0] out_min_u;
    logic [1:0] out_index_u;
    logic [2:0] out_count_u;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    metric_min_tracker #(.WIDTH(6), .NSTATES(4), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_metric(in_metric), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_min(out_min_s), .out_index(out_index_s),
        .out_count(out_count_s), .out_err(out_err_s)
    );

    metric_min_tracker #(.WIDTH(6), .NSTATES(4), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_metric(in_metric), .in_last(in_last), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_min(out_min_u), .out_index(out_index_u),
        .out_count(out_count_u), .out_err(out_err_u)
    );

    task automatic beat(input logic [5:0] m, input logic last);
        int w = 0;
        while (!in_ready_s && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        n_cmp++;
        if (in_ready_s !== 1'b1) begin
            n_err++;
            $display("FAIL beat_ready_wait: in_ready=%0b required 1", in_ready_s);
        end
        in_valid  = 1'b1;
        in_metric = m;
        in_last   = last;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (in_ready_s !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: %0b required 1", in_ready_s); end
        n_cmp++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: %0b required 0", out_valid_s); end
        n_cmp++; if (out_min_s !== 6'h00) begin n_err++; $display("FAIL reset_out_min: %0h required 0", out_min_s); end
        n_cmp++; if (out_index_s !== 2'd0) begin n_err++; $display("FAIL reset_out_index: %0d required 0", out_index_s); end
        n_cmp++; if (out_count_s !== 3'd0) begin n_err++; $display("FAIL reset_out_count: %0d required 0", out_count_s); end
        n_cmp++; if (out_err_s !== 1'b0) begin n_err++; $display("FAIL reset_out_err: %0b required 0", out_err_s); end
    endtask

    task automatic test_basic();
        beat(6'd5, 1'b0);
        beat(6'h3D, 1'b0);
        beat(6'd7, 1'b0);
        beat(6'h3D, 1'b1);
        n_cmp++; if (out_valid_s !== 1'b1) begin n_err++; $display("FAIL basic_valid: %0b required 1", out_valid_s); end
        n_cmp++; if (out_min_s !== 6'h3D) begin n_err++; $display("FAIL basic_min: %0h required 3d", out_min_s); end
        n_cmp++; if (out_index_s !== 2'd1) begin n_err++; $display("FAIL basic_index: %0d required 1", out_index_s); end
        n_cmp++; if (out_count_s !== 3'd4) begin n_err++; $display("FAIL basic_count: %0d required 4", out_count_s); end
        n_cmp++; if (out_err_s !== 1'b0) begin n_err++; $display("FAIL basic_err: %0b required 0", out_err_s); end
        release_result();
    endtask

    task automatic test_overflow();
        beat(6'd31, 1'b0);
        beat(6'h20, 1'b1);
        n_cmp++; if (out_min_s !== 6'h20) begin n_err++; $display("FAIL ovf_signed_min: %0h required 20", out_min_s); end
        n_cmp++; if (out_index_s !== 2'd1) begin n_err++; $display("FAIL ovf_signed_index: %0d required 1", out_index_s); end
        n_cmp++; if (out_count_s !== 3'd2) begin n_err++; $display("FAIL ovf_signed_count: %0d required 2", out_count_s); end
        n_cmp++; if (out_min_u !== 6'd31) begin n_err++; $display("FAIL ovf_unsigned_min: %0h required 1f", out_min_u); end
        n_cmp++; if (out_index_u !== 2'd0) begin n_err++; $display("FAIL ovf_unsigned_index: %0d required 0", out_index_u); end
        release_result();
    endtask

    task automatic test_no_last();
        beat(6'd2, 1'b0);
        beat(6'd1, 1'b0);
        beat(6'd3, 1'b0);
        beat(6'd0, 1'b0);
        n_cmp++; if (out_valid_s !== 1'b1) begin n_err++; $display("FAIL nolast_valid: %0b required 1", out_valid_s); end
        n_cmp++; if (out_min_s !== 6'd0) begin n_err++; $display("FAIL nolast_min: %0h required 0", out_min_s); end
        n_cmp++; if (out_index_s !== 2'd3) begin n_err++; $display("FAIL nolast_index: %0d required 3", out_index_s); end
        n_cmp++; if (out_count_s !== 3'd4) begin n_err++; $display("FAIL nolast_count: %0d required 4", out_count_s); end
        n_cmp++; if (out_err_s !== 1'b1) begin n_err++; $display("FAIL nolast_err: %0b required 1", out_err_s); end
        n_cmp++; if (out_err_u !== 1'b1) begin n_err++; $display("FAIL nolast_err_unsigned: %0b required 1", out_err_u); end
        release_result();
        beat(6'd6, 1'b0);
        beat(6'd8, 1'b1);
        n_cmp++; if (out_min_s !== 6'd6) begin n_err++; $display("FAIL fresh_min: %0h required 6", out_min_s); end
        n_cmp++; if (out_index_s !== 2'd0) begin n_err++; $display("FAIL fresh_index: %0d required 0", out_index_s); end
        n_cmp++; if (out_count_s !== 3'd2) begin n_err++; $display("FAIL fresh_count: %0d required 2", out_count_s); end
        n_cmp++; if (out_err_s !== 1'b0) begin n_err++; $display("FAIL fresh_err: %0b required 0", out_err_s); end
        release_result();
    endtask

    task automatic test_backpressure();
        beat(6'd1, 1'b0);
        beat(6'd2, 1'b1);
        in_valid  = 1'b1;
        in_metric = 6'd0;
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid_s !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: %0b required 1", i, out_valid_s); end
            n_cmp++; if (in_ready_s !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: %0b required 0", i, in_ready_s); end
            n_cmp++; if (out_min_s !== 6'd1) begin n_err++; $display("FAIL bp_min[%0d]: %0h required 1", i, out_min_s); end
            n_cmp++; if (out_count_s !== 3'd2) begin n_err++; $display("FAIL bp_count[%0d]: %0d required 2", i, out_count_s); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        n_cmp++; if (in_ready_s !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: %0b required 1", in_ready_s); end
        n_cmp++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: %0b required 0", out_valid_s); end
        beat(6'd3, 1'b1);
        n_cmp++; if (out_min_s !== 6'd3) begin n_err++; $display("FAIL bp_next_min: %0h required 3", out_min_s); end
        n_cmp++; if (out_count_s !== 3'd1) begin n_err++; $display("FAIL bp_next_count: %0d required 1", out_count_s); end
        release_result();
    endtask

    task automatic test_single();
        n_cmp++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL single_idle_valid: %0b required 0", out_valid_s); end
        beat(6'h3F, 1'b1);
        n_cmp++; if (out_valid_s !== 1'b1) begin n_err++; $display("FAIL single_valid: %0b required 1", out_valid_s); end
        n_cmp++; if (out_min_s !== 6'h3F) begin n_err++; $display("FAIL single_min: %0h required 3f", out_min_s); end
        n_cmp++; if (out_index_s !== 2'd0) begin n_err++; $display("FAIL single_index: %0d required 0", out_index_s); end
        n_cmp++; if (out_count_s !== 3'd1) begin n_err++; $display("FAIL single_count: %0d required 1", out_count_s); end
        release_result();
    endtask

    task automatic test_reset_mid();
        beat(6'd7, 1'b0);
        beat(6'd1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL rmid_valid: %0b required 0", out_valid_s); end
        n_cmp++; if (out_count_s !== 3'd0) begin n_err++; $display("FAIL rmid_count_cleared: %0d required 0", out_count_s); end
        beat(6'd4, 1'b0);
        beat(6'd9, 1'b1);
        n_cmp++; if (out_min_s !== 6'd4) begin n_err++; $display("FAIL rmid_min: %0h required 4", out_min_s); end
        n_cmp++; if (out_index_s !== 2'd0) begin n_err++; $display("FAIL rmid_index: %0d required 0", out_index_s); end
        n_cmp++; if (out_count_s !== 3'd2) begin n_err++; $display("FAIL rmid_count: %0d required 2", out_count_s); end
        n_cmp++; if (out_err_s !== 1'b0) begin n_err++; $display("FAIL rmid_err: %0b required 0", out_err_s); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_no_last();
        test_backpressure();
        test_single();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
